// File: rtl/demux_scan_ctrl.sv
// Channel-select sequencer for the 1x16 demux: steps sel across enabled
// channels with a programmable dwell, gating serial data onto the demux input.
module demux_scan_ctrl #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [15:0]        ch_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               data_in,
    output logic [3:0]         sel,
    output logic               inp,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    localparam int unsigned CH_N  = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               busy_nxt, done_nxt, wrap_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [CH_N-1:0]    ch_snap, ch_snap_nxt;
    logic [DWELL_W-1:0] dwell_snap, dwell_snap_nxt;
    logic               mode_snap, mode_snap_nxt;
    logic [CH_N-1:0]    above;
    logic               dwell_end;

    // Priority pick of the lowest set bit in a channel mask.
    function automatic logic [SEL_W-1:0] lowest(input logic [CH_N-1:0] m);
        lowest = '0;
        for (int i = CH_N - 1; i >= 0; i--) begin
            if (m[i]) lowest = SEL_W'(i);
        end
    endfunction

    assign above     = ch_snap & ({{(CH_N-1){1'b1}}, 1'b0} << sel);
    assign dwell_end = (cnt == dwell_snap);
    assign inp       = data_in & busy;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
            cnt        <= '0;
            ch_snap    <= '0;
            dwell_snap <= '0;
            mode_snap  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            wrap       <= wrap_nxt;
            cnt        <= cnt_nxt;
            ch_snap    <= ch_snap_nxt;
            dwell_snap <= dwell_snap_nxt;
            mode_snap  <= mode_snap_nxt;
        end
    end

    // Next-state logic; stop overrides everything.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start && ch_en != '0) state_nxt = SCAN;
                SCAN: if (dwell_end && above == '0 && !mode_snap) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, counter and snapshots.
    always_comb begin
        sel_nxt        = sel;
        cnt_nxt        = cnt;
        done_nxt       = 1'b0;
        wrap_nxt       = 1'b0;
        ch_snap_nxt    = ch_snap;
        dwell_snap_nxt = dwell_snap;
        mode_snap_nxt  = mode_snap;
        busy_nxt       = (state_nxt == SCAN);
        if (stop) begin
            sel_nxt = '0;
            cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && ch_en != '0) begin
                        ch_snap_nxt    = ch_en;
                        dwell_snap_nxt = dwell;
                        mode_snap_nxt  = mode;
                        sel_nxt        = lowest(ch_en);
                        cnt_nxt        = '0;
                    end else if (start) begin
                        done_nxt = 1'b1;
                    end
                end
                SCAN: begin
                    if (!dwell_end) begin
                        cnt_nxt = cnt + DWELL_W'(1);
                    end else begin
                        cnt_nxt = '0;
                        if (above != '0) begin
                            sel_nxt = lowest(above);
                        end else if (mode_snap) begin
                            sel_nxt  = lowest(ch_snap);
                            wrap_nxt = 1'b1;
                        end else begin
                            sel_nxt  = '0;
                            done_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    sel_nxt = '0;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule
